mod8_down_timer: RTL
====================

MOD8_DOWN_TIMER -- requirements
Module: mod8_down_timer

Interface
REQ-001 The block SHALL have no parameters; count width is fixed at 3 bits.
REQ-002 CLK  input  1  single clock; all state updates on its falling edge.
REQ-003 RST  input  1  asynchronous, active-high reset.
REQ-004 LOAD  input  1  load start value D and arm the timer.
REQ-005 D  input  3  start/reload value, 0..7.
REQ-006 I  input  1  count enable; decrement when 1.
REQ-007 MODE  input  1  0 = one-shot, 1 = auto-reload.
REQ-008 Q  output  3  current count, registered.
REQ-009 LED  output  1  terminal-count indicator, registered.
REQ-010 BUSY  output  1  1 while in RUN or HOLD.
REQ-011 STATE  output  2  FSM state: IDLE=00, RUN=01, HOLD=10, DONE=11.

Function
REQ-012 The block SHALL register a 3-bit reload value RV, written with D on every accepted LOAD.
REQ-013 IDLE: Q holds. LOAD=1 sets Q<=D and RV<=D. The next state is RUN if D!=0, or DONE if D==0. LOAD=0 stays in IDLE.
REQ-014 RUN, LOAD=1 (priority over I): Q<=D and RV<=D. Go to DONE if D==0, else stay in RUN. LED<=0.
REQ-015 RUN, LOAD=0, I=0: go to HOLD; Q holds.
REQ-016 RUN, LOAD=0, I=1, Q>1: Q<=Q-1; stay in RUN.
REQ-017 RUN, LOAD=0, I=1, Q==1, MODE=0: Q<=0 and go to DONE.
REQ-018 RUN, LOAD=0, I=1, Q==1, MODE=1: Q<=RV, stay in RUN, and LED pulses high for exactly one cycle.
REQ-019 HOLD: LOAD=1 behaves as in RUN. Otherwise I=1 applies the RUN decrement rules in the same cycle and goes to RUN; I=0 stays in HOLD with Q held.
REQ-020 DONE: Q=0 and LED=1 steady. I is ignored. LOAD=1 behaves as in IDLE and clears LED at the same edge.
REQ-021 LED SHALL be 0 in IDLE, RUN and HOLD, except for the REQ-018 one-cycle pulse.
REQ-022 MODE SHALL be sampled only at the Q==1 decision edge; changing MODE mid-count has no other effect.
REQ-023 Q SHALL never wrap from 0 to 7; no decrement occurs at Q==0.
REQ-024 BUSY SHALL be a registered decode of the state.
REQ-025 No combinational path from any input to any output is permitted.

Reset
REQ-026 When RST=1, the block SHALL asynchronously force STATE=IDLE, Q=0, RV=0, LED=0 and BUSY=0, regardless of CLK.
REQ-027 Reset asserted mid-count SHALL abort the count with no LED pulse. After reset release, the block waits in IDLE for LOAD.

Verification
REQ-028 Reset, then LOAD with D=3, MODE=0, I held 1: Q = 3,2,1,0 on successive falling edges. STATE reaches DONE together with Q=0. LED=1 and BUSY=0 from that edge on.
REQ-029 LOAD with D=2, MODE=1, I=1: Q = 2,1,2,1,... LED high for one cycle at each 1->2 reload. STATE stays RUN.
REQ-030 LOAD with D=5, I=1 for 2 edges then I=0 for 3 edges: Q = 5,4,3 then holds 3 with STATE=HOLD. Raising I resumes with Q=2.
REQ-031 LOAD with D=0: the next edge gives STATE=DONE, Q=0, LED=1. The same result occurs when D=0 is loaded from RUN.
REQ-032 While Q=4 in RUN with I=1, LOAD with D=6: Q=6 (LOAD wins over I). A RST pulse between falling edges forces Q=0, STATE=IDLE and LED=0 immediately.

Source files
------------

// File: rtl/mod8_down_timer.sv
// 3-bit falling-edge down timer with one-shot / auto-reload modes.
// LOAD arms the count; the terminal count either parks the timer in DONE or reloads it.
module mod8_down_timer (
    input  logic       CLK,
    input  logic       RST,
    input  logic       LOAD,
    input  logic [2:0] D,
    input  logic       I,
    input  logic       MODE,
    output logic [2:0] Q,
    output logic       LED,
    output logic       BUSY,
    output logic [1:0] STATE
);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        HOLD = 2'b10,
        DONE = 2'b11
    } state_t;

    state_t     state, state_nx;
    logic [2:0] rv, rv_nx, q_nx;
    logic       reload_pulse, led_nx, busy_nx;

    always_comb begin
        // NOTE: every combinational output gets a default first so no path can infer a latch.
        state_nx     = state;
        q_nx         = Q;
        rv_nx        = rv;
        reload_pulse = 1'b0;

        case (state)
            IDLE, DONE: begin
                if (LOAD) begin
                    q_nx     = D;
                    rv_nx    = D;
                    state_nx = (D == 3'd0) ? DONE : RUN;
                end
            end
            RUN, HOLD: begin
                if (LOAD) begin
                    q_nx     = D;
                    rv_nx    = D;
                    state_nx = (D == 3'd0) ? DONE : RUN;
                end else if (!I) begin
                    state_nx = HOLD;
                end else if (Q > 3'd1) begin
                    q_nx     = Q - 3'd1;
                    state_nx = RUN;
                end else if (Q == 3'd1) begin
                    // MODE only matters here, at the terminal-count decision.
                    if (MODE) begin
                        q_nx         = rv;
                        reload_pulse = 1'b1;
                        state_nx     = RUN;
                    end else begin
                        q_nx     = 3'd0;
                        state_nx = DONE;
                    end
                end else begin
                    // Q==0 while armed cannot decrement; park instead of wrapping.
                    state_nx = DONE;
                end
            end
            default: state_nx = IDLE;
        endcase

        led_nx  = (state_nx == DONE) || reload_pulse;
        busy_nx = (state_nx == RUN) || (state_nx == HOLD);
    end

    always_ff @(negedge CLK or posedge RST) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (RST) begin
            state <= IDLE;
            Q     <= 3'd0;
            rv    <= 3'd0;
            LED   <= 1'b0;
            BUSY  <= 1'b0;
        end else begin
            state <= state_nx;
            Q     <= q_nx;
            rv    <= rv_nx;
            LED   <= led_nx;
            BUSY  <= busy_nx;
        end
    end

    assign STATE = state;

endmodule
